nfc_command_dispatcher: RTL and testbench

//  Sits downstream of the AXI-Lite register block. Captures each one-cycle command-write pulse together with its

---
 rtl/nfc_command_dispatcher_pkg.sv | 34 +++
 rtl/nfc_command_dispatcher_fifo.sv | 48 ++++
 rtl/nfc_command_dispatcher.sv | 114 +++++++++++
 tb/tb_nfc_command_dispatcher.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/nfc_command_dispatcher_pkg.sv
// nfc_command_dispatcher_pkg: opcodes, FSM states, queue entry layout and opcode check shared by the dispatcher
package nfc_command_dispatcher_pkg;

    localparam logic [7:0] OP_RESET    = 8'h01;
    localparam logic [7:0] OP_SETFEAT  = 8'h02;
    localparam logic [7:0] OP_READID   = 8'h03;
    localparam logic [7:0] OP_READPAGE = 8'h04;
    localparam logic [7:0] OP_PROGPAGE = 8'h05;
    localparam logic [7:0] OP_ERASE    = 8'h06;
    localparam logic [7:0] OP_READSTAT = 8'h07;
    localparam logic [7:0] OP_CLRERR   = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [2:0]  way;
        logic [31:0] addr;
        logic [15:0] len;
        logic [31:0] dmar;
        logic [31:0] dmaw;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    function automatic logic is_nand_op(input logic [7:0] op);
        return op >= OP_RESET && op <= OP_READSTAT;
    endfunction

endpackage

// File: rtl/nfc_command_dispatcher_fifo.sv
// nfc_command_dispatcher_fifo: synchronous first-word-fall-through FIFO, accepts push on full when popping
module nfc_command_dispatcher_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // entry storage, no reset needed since empty gates every read
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/nfc_command_dispatcher.sv
// nfc_command_dispatcher: queues register-block commands and issues them in order to the NAND way controller
module nfc_command_dispatcher
    import nfc_command_dispatcher_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int NUM_WAYS       = 8,
    parameter int TIMEOUT_CYCLES = 1000000,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] iCommand,
    input  logic        iCommandValid,
    input  logic [31:0] iAddress,
    input  logic [15:0] iLength,
    input  logic [31:0] iDMARAddress,
    input  logic [31:0] iDMAWAddress,
    input  logic [31:0] iNandRBStatus,
    output logic        oOpValid,
    input  logic        iOpReady,
    output logic [7:0]  oOpCode,
    output logic [2:0]  oOpWay,
    output logic [31:0] oOpAddress,
    output logic [15:0] oOpLength,
    output logic [31:0] oOpDMARAddr,
    output logic [31:0] oOpDMAWAddr,
    input  logic        iOpDone,
    output logic        oCommandFail,
    output logic [23:0] oNFCStatus
);

    state_e        state_q, state_d;
    entry_t        op_q, head, new_entry;
    logic [31:0]   cnt_q, cnt_d;
    logic [2:0]    err_q, err_d;
    logic [CW-1:0] count;
    logic          full, empty;
    logic          cmd_ok, clr, inval, push, pop, ovf, tmo;
    logic          unused;

    assign unused = ^iCommand[31:11];

    assign new_entry = '{opcode: iCommand[7:0], way: iCommand[10:8], addr: iAddress,
                         len: iLength, dmar: iDMARAddress, dmaw: iDMAWAddress};

    assign clr    = iCommandValid && iCommand[7:0] == OP_CLRERR;
    assign cmd_ok = iCommandValid && is_nand_op(iCommand[7:0]) && int'(iCommand[10:8]) < NUM_WAYS;
    assign inval  = iCommandValid && !clr && !cmd_ok;
    assign pop    = state_q == ST_IDLE && !empty && iNandRBStatus[head.way];
    assign push   = cmd_ok && (!full || pop);
    assign ovf    = cmd_ok && full && !pop;

    nfc_command_dispatcher_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .pop_i  (pop),
        .din_i  (new_entry),
        .head_o (head),
        .full_o (full),
        .empty_o(empty),
        .count_o(count)
    );

    // next state, timeout counter and sticky error accumulation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo     = 1'b0;
        case (state_q)
            ST_IDLE:  state_d = pop ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: begin
                state_d = iOpReady ? ST_WAIT : ST_ISSUE;
                cnt_d   = iOpReady ? '0 : cnt_q;
            end
            ST_WAIT: begin
                tmo     = !iOpDone && cnt_q == 32'(TIMEOUT_CYCLES - 1);
                state_d = (iOpDone || tmo) ? ST_IDLE : ST_WAIT;
                cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
            end
            default:  state_d = ST_IDLE;
        endcase
        err_d = clr ? 3'b000 : err_q | {tmo, inval, ovf};
    end

    // state, counter, errors and the op register loaded when the head is popped
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (pop) op_q <= head;
        end
    end

    assign oOpValid     = state_q == ST_ISSUE && !rst;
    assign oOpCode      = op_q.opcode;
    assign oOpWay       = op_q.way;
    assign oOpAddress   = op_q.addr;
    assign oOpLength    = op_q.len;
    assign oOpDMARAddr  = op_q.dmar;
    assign oOpDMAWAddr  = op_q.dmaw;
    assign oCommandFail = |err_q;
    assign oNFCStatus   = {op_q.opcode, 8'(count), state_q, full, empty, state_q != ST_IDLE, err_q};

endmodule

// File: tb/tb_nfc_command_dispatcher.sv
// tb_nfc_command_dispatcher: directed stimulus with a scoreboard checking every issued operation
module tb_nfc_command_dispatcher;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] iCommand;
    logic        iCommandValid;
    logic [31:0] iAddress;
    logic [15:0] iLength;
    logic [31:0] iDMARAddress;
    logic [31:0] iDMAWAddress;
    logic [31:0] iNandRBStatus;
    logic        oOpValid;
    logic        iOpReady;
    logic [7:0]  oOpCode;
    logic [2:0]  oOpWay;
    logic [31:0] oOpAddress;
    logic [15:0] oOpLength;
    logic [31:0] oOpDMARAddr;
    logic [31:0] oOpDMAWAddr;
    logic        iOpDone;
    logic        oCommandFail;
    logic [23:0] oNFCStatus;

    int n_cmp = 0;
    int n_bad = 0;
    logic [122:0] exp_q[$];
    logic [122:0] got, e;

    always #5 clk = ~clk;

    nfc_command_dispatcher #(
        .FIFO_DEPTH(4),
        .NUM_WAYS(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .iCommand(iCommand), .iCommandValid(iCommandValid),
        .iAddress(iAddress), .iLength(iLength),
        .iDMARAddress(iDMARAddress), .iDMAWAddress(iDMAWAddress),
        .iNandRBStatus(iNandRBStatus),
        .oOpValid(oOpValid), .iOpReady(iOpReady),
        .oOpCode(oOpCode), .oOpWay(oOpWay), .oOpAddress(oOpAddress),
        .oOpLength(oOpLength), .oOpDMARAddr(oOpDMARAddr), .oOpDMAWAddr(oOpDMAWAddr),
        .iOpDone(iOpDone), .oCommandFail(oCommandFail), .oNFCStatus(oNFCStatus)
    );

    assign got = {oOpCode, oOpWay, oOpAddress, oOpLength, oOpDMARAddr, oOpDMAWAddr};

    // monitor: every accepted operation must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && oOpValid && iOpReady) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL op_unexpected got=%h required=none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL op_fields got=%h required=%h", got, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask

    task automatic wr(input logic [7:0] op, input logic [2:0] w, input logic [31:0] a,
                      input logic [15:0] len, input logic exp);
        iCommand      = {21'd0, w, op};
        iAddress      = a;
        iLength       = len;
        iDMARAddress  = a + 32'h1000_0000;
        iDMAWAddress  = a + 32'h2000_0000;
        iCommandValid = 1'b1;
        if (exp) exp_q.push_back({op, w, a, len, a + 32'h1000_0000, a + 32'h2000_0000});
        tick(1);
        iCommandValid = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50 && !oOpValid; i++) tick(1);
        chk("wait_valid", {31'd0, oOpValid}, 32'd1);
    endtask

    task automatic serve();
        wait_valid();
        iOpReady = 1'b1;
        tick(1);
        iOpReady = 1'b0;
        tick(2);
        iOpDone = 1'b1;
        tick(1);
        iOpDone = 1'b0;
        tick(1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; iCommand = '0; iCommandValid = 1'b0; iAddress = '0; iLength = '0;
        iDMARAddress = '0; iDMAWAddress = '0; iNandRBStatus = 32'hFF; iOpReady = 1'b0; iOpDone = 1'b0;
        tick(3);
        rst = 1'b0;
        chk("reset_status", {8'd0, oNFCStatus}, 32'h10);
        chk("reset_fail", {31'd0, oCommandFail}, 32'd0);
        chk("reset_valid", {31'd0, oOpValid}, 32'd0);
        chk("reset_addr", oOpAddress, 32'd0);

        wr(8'h04, 3'd1, 32'h0001_2000, 16'd4096, 1'b1);
        chk("t1_count_n1", {24'd0, oNFCStatus[15:8]}, 32'd1);
        chk("t1_valid_n1", {31'd0, oOpValid}, 32'd0);
        tick(1);
        chk("t1_valid_n2", {31'd0, oOpValid}, 32'd1);
        chk("t1_code", {24'd0, oOpCode}, 32'h04);
        chk("t1_way", {29'd0, oOpWay}, 32'd1);
        chk("t1_addr", oOpAddress, 32'h0001_2000);
        chk("t1_len", {16'd0, oOpLength}, 32'd4096);
        chk("t1_last_op", {24'd0, oNFCStatus[23:16]}, 32'h04);
        chk("t1_state_issue", {30'd0, oNFCStatus[7:6]}, 32'd1);
        iOpReady = 1'b1;
        tick(1);
        iOpReady = 1'b0;
        chk("t1_state_wait", {30'd0, oNFCStatus[7:6]}, 32'd2);
        tick(9);
        iOpDone = 1'b1;
        tick(1);
        iOpDone = 1'b0;
        chk("t1_state_idle", {30'd0, oNFCStatus[7:6]}, 32'd0);
        chk("t1_busy", {31'd0, oNFCStatus[3]}, 32'd0);

        for (int i = 0; i < 5; i++)
            wr(8'h05, 3'(i), 32'h100 * (i + 1), 16'(64 * (i + 1)), 1'b1);
        chk("t2_count", {24'd0, oNFCStatus[15:8]}, 32'd4);
        chk("t2_full", {31'd0, oNFCStatus[5]}, 32'd1);
        chk("t2_state", {30'd0, oNFCStatus[7:6]}, 32'd1);
        chk("t2_no_err", {29'd0, oNFCStatus[2:0]}, 32'd0);
        wr(8'h05, 3'd6, 32'h600, 16'd8, 1'b0);
        chk("t2_overflow", {31'd0, oNFCStatus[0]}, 32'd1);
        chk("t2_fail", {31'd0, oCommandFail}, 32'd1);
        chk("t2_count_after", {24'd0, oNFCStatus[15:8]}, 32'd4);

        wr(8'h09, 3'd0, 32'h900, 16'd8, 1'b0);
        chk("t3_invalid", {31'd0, oNFCStatus[1]}, 32'd1);
        chk("t3_count", {24'd0, oNFCStatus[15:8]}, 32'd4);
        wr(8'hFF, 3'd0, 32'h0, 16'd0, 1'b0);
        chk("t3_cleared", {29'd0, oNFCStatus[2:0]}, 32'd0);
        chk("t3_fail", {31'd0, oCommandFail}, 32'd0);
        repeat (5) serve();
        chk("t3_drained", {24'd0, oNFCStatus[15:8]}, 32'd0);
        chk("t3_idle", {30'd0, oNFCStatus[7:6]}, 32'd0);

        wr(8'h06, 3'd3, 32'h3000, 16'd16, 1'b1);
        wr(8'h07, 3'd4, 32'h4000, 16'd1, 1'b1);
        wait_valid();
        iOpReady = 1'b1;
        tick(1);
        iOpReady = 1'b0;
        tick(15);
        chk("t4_no_tmo_15", {31'd0, oNFCStatus[2]}, 32'd0);
        chk("t4_wait_15", {30'd0, oNFCStatus[7:6]}, 32'd2);
        tick(1);
        chk("t4_tmo_16", {31'd0, oNFCStatus[2]}, 32'd1);
        chk("t4_idle", {30'd0, oNFCStatus[7:6]}, 32'd0);
        chk("t4_fail", {31'd0, oCommandFail}, 32'd1);
        tick(1);
        chk("t4_next_valid", {31'd0, oOpValid}, 32'd1);
        chk("t4_next_way", {29'd0, oOpWay}, 32'd4);
        serve();
        wr(8'hFF, 3'd0, 32'h0, 16'd0, 1'b0);

        iNandRBStatus = 32'hFB;
        wr(8'h01, 3'd2, 32'h2222, 16'd2, 1'b1);
        wr(8'h02, 3'd0, 32'h0101, 16'd3, 1'b1);
        tick(3);
        chk("t5_blocked", {31'd0, oOpValid}, 32'd0);
        chk("t5_count", {24'd0, oNFCStatus[15:8]}, 32'd2);
        iNandRBStatus = 32'hFF;
        tick(1);
        chk("t5_valid", {31'd0, oOpValid}, 32'd1);
        chk("t5_way2_first", {29'd0, oOpWay}, 32'd2);
        serve();
        serve();

        wr(8'h03, 3'd5, 32'h5000, 16'd4, 1'b1);
        wr(8'h04, 3'd6, 32'h6000, 16'd4, 1'b0);
        wr(8'h05, 3'd7, 32'h7000, 16'd4, 1'b0);
        wr(8'h01, 3'd5, 32'h5100, 16'd4, 1'b0);
        wait_valid();
        iOpReady = 1'b1;
        tick(1);
        iOpReady = 1'b0;
        chk("t6_wait", {30'd0, oNFCStatus[7:6]}, 32'd2);
        chk("t6_count", {24'd0, oNFCStatus[15:8]}, 32'd3);
        rst = 1'b1;
        tick(1);
        chk("t6_rst_valid", {31'd0, oOpValid}, 32'd0);
        chk("t6_rst_status", {8'd0, oNFCStatus}, 32'h10);
        rst = 1'b0;
        iOpDone = 1'b1;
        tick(1);
        iOpDone = 1'b0;
        tick(4);
        chk("t6_done_ignored", {8'd0, oNFCStatus}, 32'h10);
        chk("t6_no_valid", {31'd0, oOpValid}, 32'd0);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
